// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32 instruction fetch path.
package riscv_pkg;

    localparam int               XLEN             = 32;
    localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]      NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head is read straight from registered storage
// and reads as zero while the FIFO is empty.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0],
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  T                 push_data,
    output T                 head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, response buffering
// and redirect handling. Optional counters are enabled with FETCH_STATS_EN.
module fetch_stage #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed,
`endif
    output logic [XLEN-1:0] if_pc_plus4
);

    import riscv_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credits_used;
    logic            resp_ok;
    logic            issued;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsbs;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign credits_used         = {1'b0, outstanding} + {1'b0, fifo_count};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Requests only go out while in-flight plus buffered words leave room in the FIFO.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     imem_req = fetch_en && !redirect_valid &&
                                (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
            default: state_next = BOOT;
        endcase
    end

    // A response with nothing outstanding is a leftover from before reset and is ignored.
    assign resp_ok          = imem_rvalid && (outstanding != '0);
    assign issued           = imem_req && imem_gnt;
    assign outstanding_next = outstanding + CNT_W'(issued) - CNT_W'(resp_ok);
    assign push             = resp_ok && !redirect_valid && (discard == '0);
    assign pop              = if_valid && if_ready && !redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc      <= redirect_target;
                resp_pc <= redirect_target;
                discard <= outstanding_next;
            end else begin
                if (issued) begin
                    pc <= pc + XLEN'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (resp_ok && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    assign push_entry = '{instr: imem_rdata, pc: resp_pc};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (head),
        .count     (fifo_count)
    );

    assign imem_addr   = pc;
    assign if_valid    = (fifo_count != '0);
    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head.pc + XLEN'(4);

`ifdef FETCH_STATS_EN
    logic [31:0] flushed_now;

    // Flushed work is the buffered entries plus any response thrown away because of a redirect.
    always_comb begin
        flushed_now = 32'd0;
        if (redirect_valid) begin
            flushed_now = 32'(fifo_count) + 32'(resp_ok);
        end else if (resp_ok && (discard != '0)) begin
            flushed_now = 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched <= 32'd0;
            stat_flushed <= 32'd0;
        end else begin
            stat_fetched <= stat_fetched + 32'(pop);
            stat_flushed <= stat_flushed + flushed_now;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table plus randomized traffic
// against a queue-based reference model and an in-order memory with variable latency.
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
`ifdef FETCH_STATS_EN
        .stat_fetched   (stat_fetched),
        .stat_flushed   (stat_flushed),
`endif
        .if_pc_plus4    (if_pc_plus4)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] addr;
        int          rc;
    } mreq_t;

    typedef struct {
        bit          rst;
        int          lat;
        bit          fe;
        bit          gnt;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    ent_t        m_fifo[$];
    flight_t     m_inflight[$];
    mreq_t       mem_q[$];
    vec_t        tbl[$];
    bit          m_booted;
    logic [31:0] m_pc;
    bit          exp_req;
    bit          s_req;
    logic [31:0] s_addr;
    int          cyc;
    int          mem_lat;
    int          last_rc;
    int          vec_count = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_fifo.delete();
        m_inflight.delete();
        mem_q.delete();
        m_booted = 1'b0;
        m_pc     = 32'h0;
        last_rc  = 0;
        cyc      = 0;
    endtask

    task automatic quietInputs();
        fetch_en       = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
    endtask

    task automatic checkResetOutputs();
        cmp("rst_imem_req", 32'(imem_req), 32'h0);
        cmp("rst_if_valid", 32'(if_valid), 32'h0);
        cmp("rst_if_instr", if_instr, 32'h0);
        cmp("rst_if_pc", if_pc, 32'h0);
    endtask

    // Hold reset across a clock edge, then release it at a falling edge.
    task automatic doReset();
        reset = 1'b1;
        quietInputs();
        modelReset();
        @(posedge clk);
        #1;
        checkResetOutputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Asynchronous reset between edges while traffic is in flight.
    task automatic midReset();
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs();
        quietInputs();
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input bit fe, input bit gnt, input bit rdy, input bit redir,
                                 input logic [31:0] rpc);
        fetch_en       = fe;
        imem_gnt       = gnt;
        if_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_q.size() > 0 && mem_q[0].rc <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        exp_req = m_booted && fe && !redir && ((m_inflight.size() + m_fifo.size()) < DEPTH);
        #1;
        s_req  = imem_req;
        s_addr = imem_addr;
    endtask

    task automatic checkOutput();
        cmp("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) begin
            cmp("imem_addr", imem_addr, m_pc);
        end
        cmp("if_valid", 32'(if_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            cmp("if_pc", if_pc, m_fifo[0].pc);
            cmp("if_instr", if_instr, m_fifo[0].instr);
            cmp("if_pc_plus4", if_pc_plus4, m_fifo[0].pc + 32'd4);
        end
    endtask

    // Clock edge: update memory and the reference model from this cycle's stimulus.
    task automatic advance();
        bit      do_pop;
        flight_t f;
        @(posedge clk);
        do_pop = (m_fifo.size() > 0) && if_ready;
        if (imem_rvalid) begin
            mem_q.delete(0);
        end
        if (s_req && imem_gnt) begin
            last_rc = (cyc + mem_lat > last_rc) ? cyc + mem_lat : last_rc;
            mem_q.push_back('{addr: s_addr, rc: last_rc});
        end
        if (redirect_valid) begin
            m_fifo.delete();
            foreach (m_inflight[k]) m_inflight[k].stale = 1'b1;
            if (imem_rvalid && m_inflight.size() > 0) begin
                m_inflight.delete(0);
            end
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (do_pop) begin
                m_fifo.delete(0);
            end
            if (imem_rvalid && m_inflight.size() > 0) begin
                f = m_inflight[0];
                m_inflight.delete(0);
                if (!f.stale) begin
                    m_fifo.push_back('{instr: imem_rdata, pc: f.pc});
                end
            end
            if (exp_req && imem_gnt) begin
                m_inflight.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        m_booted = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic addVec(input bit rst, input int lat, input bit fe, input bit gnt, input bit rdy,
                          input bit redir, input logic [31:0] rpc, input bit e_req,
                          input logic [31:0] e_addr, input bit e_valid, input logic [31:0] e_pc);
        tbl.push_back('{rst: rst, lat: lat, fe: fe, gnt: gnt, rdy: rdy, redir: redir, rpc: rpc,
                        e_req: e_req, e_addr: e_addr, e_valid: e_valid, e_pc: e_pc});
    endtask

    initial begin
        bit          fe;
        bit          gnt;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;

        // Streaming with a one-cycle memory: addresses 0,4,8.. and first word at cycle 3.
        addVec(1, 1, 1, 1, 1, 0, 32'h0, 0, 32'h0,   0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0, 1, 32'h0,   0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0, 1, 32'h4,   0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0, 0, 32'h0,   1, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0, 1, 32'h8,   1, 32'h4);
        addVec(0, 1, 1, 1, 1, 0, 32'h0, 1, 32'hC,   0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0, 0, 32'h0,   1, 32'h8);
        addVec(0, 1, 1, 1, 1, 0, 32'h0, 1, 32'h10,  1, 32'hC);
        // Two requests in flight, misaligned redirect to 0x103 fetches from 0x100.
        addVec(1, 2, 1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        addVec(0, 2, 1, 1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
        addVec(0, 2, 1, 1, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0);
        addVec(0, 2, 1, 1, 0, 1, 32'h103, 0, 32'h0,   0, 32'h0);
        addVec(0, 2, 1, 1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        addVec(0, 2, 1, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        addVec(0, 2, 1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        addVec(0, 2, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h100);
        addVec(0, 2, 1, 1, 0, 0, 32'h0,   1, 32'h108, 1, 32'h104);
        // Redirect coinciding with a response and a pop.
        addVec(1, 1, 1, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
        addVec(0, 1, 1, 1, 1, 1, 32'h200, 0, 32'h0,   1, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200);
        // PC wrap from 0xFFFF_FFFC to 0.
        addVec(1, 1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        addVec(0, 1, 1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
        addVec(0, 1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC);
        // Back-to-back redirects: the second target wins, both stale words dropped.
        addVec(1, 2, 1, 1, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        addVec(0, 2, 1, 1, 1, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        addVec(0, 2, 1, 1, 1, 0, 32'h0,  1, 32'h4,  0, 32'h0);
        addVec(0, 2, 1, 1, 1, 1, 32'h40, 0, 32'h0,  0, 32'h0);
        addVec(0, 2, 1, 1, 1, 1, 32'h80, 0, 32'h0,  0, 32'h0);
        addVec(0, 2, 1, 1, 1, 0, 32'h0,  1, 32'h80, 0, 32'h0);
        addVec(0, 2, 1, 1, 1, 0, 32'h0,  1, 32'h84, 0, 32'h0);
        addVec(0, 2, 1, 1, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        addVec(0, 2, 1, 1, 1, 0, 32'h0,  0, 32'h0,  1, 32'h80);

        reset = 1'b1;
        quietInputs();
        modelReset();
        @(negedge clk);

        foreach (tbl[n]) begin
            if (tbl[n].rst) begin
                doReset();
            end
            mem_lat = tbl[n].lat;
            applyStimulus(tbl[n].fe, tbl[n].gnt, tbl[n].rdy, tbl[n].redir, tbl[n].rpc);
            checkOutput();
            cmp("tbl_req", 32'(s_req), 32'(tbl[n].e_req));
            if (tbl[n].e_req) begin
                cmp("tbl_addr", s_addr, tbl[n].e_addr);
            end
            cmp("tbl_valid", 32'(if_valid), 32'(tbl[n].e_valid));
            if (tbl[n].e_valid) begin
                cmp("tbl_pc", if_pc, tbl[n].e_pc);
                cmp("tbl_instr", if_instr, mem_word(tbl[n].e_pc));
            end
            advance();
        end

        // Randomized traffic with decode stalls, fetch_en gaps and a reset mid-stream.
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                midReset();
            end
            mem_lat = $urandom_range(1, 3);
            fe      = ($urandom % 8) != 0;
            gnt     = ($urandom % 4) != 0;
            rdy     = ((i % 50) < 10) ? 1'b0 : (($urandom % 4) != 0);
            redir   = ($urandom % 20) == 0;
            rpc     = $urandom;
            applyStimulus(fe, gnt, rdy, redir, rpc);
            checkOutput();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
